poly_tone_gen: RTL and testbench

POLY_TONE_GEN -- requirements
Module: poly_tone_gen

---
 rtl/tonegen_pkg.sv | 27 ++
 rtl/tone_channel.sv | 63 ++++++
 rtl/poly_tone_gen.sv | 166 ++++++++++++++++
 tb/tb_poly_tone_gen.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tonegen_pkg.sv
// Shared constants for the polyphonic tone generator: register map offsets,
// waveform encodings and the noise LFSR definition.
package tonegen_pkg;

    localparam logic [1:0] REG_PERIOD_LO = 2'd0;
    localparam logic [1:0] REG_PERIOD_HI = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_GLOBAL    = 2'd3;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_PULSE  = 2'b01,
        WAVE_NOISE  = 2'b10,
        WAVE_SILENT = 2'b11
    } wave_e;

    localparam int          LFSR_W     = 15;
    localparam logic [14:0] LFSR_SEED  = 15'h0001;
    // x^15 + x^14 + 1 expressed as zero-based bit positions
    localparam int          LFSR_TAP_A = 14;
    localparam int          LFSR_TAP_B = 13;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] state);
        return {state[LFSR_W-2:0], state[LFSR_TAP_A] ^ state[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone voice: period counter, 2-bit phase, waveform selection and the
// gated amplitude it contributes to the mixer.
module tone_channel #(
    parameter int DIV_W = 10,
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [DIV_W-1:0] period,
    input  logic             en,
    input  logic [1:0]       wave,
    input  logic [VOL_W-1:0] vol,
    input  logic             master_en,
    input  logic             lfsr_bit,
    output logic [VOL_W-1:0] amplitude
);
    import tonegen_pkg::*;

    logic [DIV_W-1:0] count_reg;
    logic [1:0]       phase_reg;
    logic             noise_reg;
    logic             running;
    logic             wrap;
    logic             wave_high;

    assign running = en && (period != '0);
    // ">=" rather than "==" so a period shortened below the count wraps at once
    assign wrap    = (count_reg >= (period - DIV_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            phase_reg <= 2'd0;
            noise_reg <= 1'b0;
        end else if (tick) begin
            if (!running) begin
                count_reg <= '0;
                phase_reg <= 2'd0;
            end else if (wrap) begin
                count_reg <= '0;
                phase_reg <= phase_reg + 2'd1;
                noise_reg <= lfsr_bit;
            end else begin
                count_reg <= count_reg + DIV_W'(1);
            end
        end
    end

    always_comb begin
        wave_high = 1'b0;
        case (wave_e'(wave))
            WAVE_SQUARE: wave_high = (phase_reg[1] == 1'b0);
            WAVE_PULSE:  wave_high = (phase_reg == 2'd0);
            WAVE_NOISE:  wave_high = noise_reg;
            WAVE_SILENT: wave_high = 1'b0;
            default:     wave_high = 1'b0;
        endcase
    end

    assign amplitude = (wave_high && running && master_en) ? vol : '0;

endmodule

// File: rtl/poly_tone_gen.sv
// Multi-channel tone generator: synchronised register writes, shared tick and
// noise LFSR, per-channel voices, registered mixer and 1st-order sigma-delta DAC.
module poly_tone_gen #(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 10,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 50,
    localparam int MIX_W   = VOL_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_strobe,
    input  logic [3:0]        address,
    input  logic [7:0]        data,
    output logic              signal_out,
    output logic [MIX_W-1:0]  mix_out,
    output logic [NUM_CH-1:0] active
);
    import tonegen_pkg::*;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [2:0]        sync_reg;
    logic              wr_fire;
    logic [1:0]        wr_ch;
    logic [1:0]        wr_reg;
    logic              master_en_reg;
    logic [PS_W-1:0]   ps_reg;
    logic              tick;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [VOL_W-1:0]  amp [NUM_CH];
    logic [MIX_W-1:0]  mix_next;
    logic [NUM_CH-1:0] active_next;
    logic [MIX_W-1:0]  mix_reg;
    logic [NUM_CH-1:0] active_reg;
    logic [MIX_W-1:0]  acc_reg;
    logic [MIX_W:0]    sd_sum;
    logic              signal_reg;

    // Two flops resynchronise the strobe; the third only serves edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], write_strobe};
        end
    end

    assign wr_fire = sync_reg[1] & ~sync_reg[2];
    assign wr_ch   = address[3:2];
    assign wr_reg  = address[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master_en_reg <= 1'b0;
        end else if (wr_fire && (wr_ch == 2'd0) && (wr_reg == REG_GLOBAL)) begin
            master_en_reg <= data[0];
        end
    end

    assign tick = (ps_reg == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_reg <= '0;
        end else if (tick) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_reg + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (tick) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] period_reg;
            logic             en_reg;
            logic [1:0]       wave_reg;
            logic [VOL_W-1:0] vol_reg;
            logic             sel;

            // Channel indices >= NUM_CH never match, so such writes fall away.
            assign sel = wr_fire && (wr_ch == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    period_reg <= '0;
                    en_reg     <= 1'b0;
                    wave_reg   <= 2'b00;
                    vol_reg    <= '0;
                end else if (sel) begin
                    case (wr_reg)
                        REG_PERIOD_LO: period_reg[7:0]       <= data;
                        REG_PERIOD_HI: period_reg[DIV_W-1:8] <= data[DIV_W-9:0];
                        REG_CTRL: begin
                            vol_reg  <= data[VOL_W-1:0];
                            wave_reg <= data[VOL_W+1:VOL_W];
                            en_reg   <= data[VOL_W+2];
                        end
                        default: ;
                    endcase
                end
            end

            tone_channel #(
                .DIV_W (DIV_W),
                .VOL_W (VOL_W)
            ) u_channel (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .period    (period_reg),
                .en        (en_reg),
                .wave      (wave_reg),
                .vol       (vol_reg),
                .master_en (master_en_reg),
                .lfsr_bit  (lfsr_reg[0]),
                .amplitude (amp[gi])
            );
        end
    endgenerate

    always_comb begin
        mix_next    = '0;
        active_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_next       = mix_next + MIX_W'(amp[i]);
            active_next[i] = (amp[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_reg    <= '0;
            active_reg <= '0;
        end else begin
            mix_reg    <= mix_next;
            active_reg <= active_next;
        end
    end

    // The carry out of the accumulator is the 1-bit audio stream.
    assign sd_sum = {1'b0, acc_reg} + {1'b0, mix_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            signal_reg <= 1'b0;
        end else begin
            acc_reg    <= sd_sum[MIX_W-1:0];
            signal_reg <= sd_sum[MIX_W];
        end
    end

    assign mix_out    = mix_reg;
    assign active     = active_reg;
    assign signal_out = signal_reg;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen (PRESCALE=1, NUM_CH=3): reset quiet, square,
// pulse, chord, master enable, ignored writes, mid-tone reset and noise restart.
module tb_poly_tone_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_strobe = 1'b0;
    logic [3:0] address = 4'd0;
    logic [7:0] data = 8'd0;
    logic       signal_out;
    logic [5:0] mix_out;
    logic [2:0] active;

    int checks = 0;
    int errors = 0;

    localparam int SEQ_LEN = 2200;
    logic seq [SEQ_LEN];

    poly_tone_gen #(
        .NUM_CH   (3),
        .DIV_W    (10),
        .VOL_W    (4),
        .PRESCALE (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .signal_out   (signal_out),
        .mix_out      (mix_out),
        .active       (active)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Every write occupies exactly 16 cycles so write-to-write spacing is fixed.
    task automatic write_reg(input logic [1:0] ch, input logic [1:0] rg, input logic [7:0] d);
        @(negedge clk);
        address      = {ch, rg};
        data         = d;
        write_strobe = 1'b1;
        repeat (4) @(negedge clk);
        write_strobe = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        checks++;
        if ({mix_out, signal_out, active} !== 10'd0)
            $display("FAIL reset_hold: mix=%0d sig=%0b act=%b, required all 0", mix_out, signal_out, active);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({mix_out, signal_out, active} !== 10'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d non-zero cycles, required 0", bad);
        end
        $display("test_reset: %0d non-quiet cycles after release", bad);
    endtask

    task automatic test_square();
        logic       found;
        logic [5:0] prev;
        int hi, lo, ones, bad;
        write_reg(2'd0, 2'd0, 8'd4);
        write_reg(2'd0, 2'd1, 8'd0);
        write_reg(2'd0, 2'd3, 8'h01);
        write_reg(2'd0, 2'd2, 8'h4F);
        found = 1'b0;
        prev  = mix_out;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prev == 6'd0 && mix_out == 6'd15) found = 1'b1;
            else prev = mix_out;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL square_rise: no 0->15 edge seen, required one within 64 cycles");
        end
        hi = 0; bad = 0;
        while (mix_out == 6'd15 && hi < 40) begin
            if (active !== 3'b001) bad++;
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (mix_out == 6'd0 && lo < 40) begin
            if (active !== 3'b000) bad++;
            lo++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 8) begin
            errors++;
            $display("FAIL square_high_run: %0d cycles, required 8", hi);
        end
        checks++;
        if (lo !== 8) begin
            errors++;
            $display("FAIL square_low_run: %0d cycles, required 8", lo);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL square_active: %0d wrong cycles, required 0", bad);
        end
        // 128 cycles hold mix total 960 = 15*64, so exactly 15 carries
        ones = 0;
        for (int i = 0; i < 128; i++) begin
            if (signal_out === 1'b1) ones++;
            @(negedge clk);
        end
        checks++;
        if (ones !== 15) begin
            errors++;
            $display("FAIL square_sd_duty: %0d ones in 128, required 15", ones);
        end
        $display("test_square: high=%0d low=%0d sd_ones=%0d", hi, lo, ones);
    endtask

    task automatic test_pulse();
        logic       found;
        logic [5:0] prev;
        int hi, lo, bad;
        write_reg(2'd0, 2'd2, 8'h0F);
        write_reg(2'd1, 2'd0, 8'd2);
        write_reg(2'd1, 2'd3, 8'h00);
        write_reg(2'd1, 2'd2, 8'h58);
        found = 1'b0;
        prev  = mix_out;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prev == 6'd0 && mix_out == 6'd8) found = 1'b1;
            else prev = mix_out;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL pulse_rise: no 0->8 edge seen, required one within 64 cycles");
        end
        hi = 0; bad = 0;
        while (mix_out == 6'd8 && hi < 40) begin
            if (active !== 3'b010) bad++;
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (mix_out == 6'd0 && lo < 40) begin
            if (active !== 3'b000) bad++;
            lo++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 2) begin
            errors++;
            $display("FAIL pulse_high_run: %0d cycles, required 2", hi);
        end
        checks++;
        if (lo !== 6) begin
            errors++;
            $display("FAIL pulse_low_run: %0d cycles, required 6", lo);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pulse_active: %0d wrong cycles, required 0", bad);
        end
        $display("test_pulse: high=%0d low=%0d active_bad=%0d", hi, lo, bad);
    endtask

    task automatic test_chord();
        int mx, n30, other;
        write_reg(2'd1, 2'd2, 8'h0F);
        write_reg(2'd1, 2'd0, 8'd4);
        write_reg(2'd0, 2'd2, 8'h4F);
        write_reg(2'd1, 2'd2, 8'h4F);
        mx = 0; n30 = 0; other = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (int'(mix_out) > mx) mx = int'(mix_out);
            if (mix_out == 6'd30) n30++;
            else if (mix_out != 6'd0) other++;
        end
        checks++;
        if (mx !== 30) begin
            errors++;
            $display("FAIL chord_peak: max %0d, required 30", mx);
        end
        checks++;
        if (n30 !== 24) begin
            errors++;
            $display("FAIL chord_high_count: %0d of 48, required 24", n30);
        end
        checks++;
        if (other !== 0) begin
            errors++;
            $display("FAIL chord_misaligned: %0d samples not 0/30, required 0", other);
        end
        $display("test_chord: peak=%0d n30=%0d other=%0d", mx, n30, other);
    endtask

    task automatic test_master();
        int bad;
        logic found;
        write_reg(2'd0, 2'd3, 8'h00);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mix_out !== 6'd0 || active !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL master_off: %0d audible cycles, required 0", bad);
        end
        write_reg(2'd0, 2'd3, 8'h01);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (mix_out == 6'd30) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL master_on: mix never 30, required 30 within 64 cycles");
        end
        $display("test_master: off_bad=%0d on_found=%0b", bad, found);
    endtask

    task automatic test_ignored();
        int bad;
        logic found;
        write_reg(2'd0, 2'd2, 8'h0F);
        write_reg(2'd1, 2'd2, 8'h0F);
        write_reg(2'd3, 2'd2, 8'h4F);
        write_reg(2'd3, 2'd0, 8'd4);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mix_out !== 6'd0 || active !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ignored_ch3: %0d audible cycles, required 0", bad);
        end
        write_reg(2'd0, 2'd0, 8'd0);
        write_reg(2'd0, 2'd2, 8'h4F);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mix_out !== 6'd0 || active !== 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL period_zero: %0d audible cycles, required 0", bad);
        end
        write_reg(2'd0, 2'd0, 8'd4);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (mix_out == 6'd15) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL period_restore: mix never 15, required 15 within 64 cycles");
        end
        $display("test_ignored: period_zero_bad=%0d restore=%0b", bad, found);
    endtask

    task automatic test_reset_mid();
        int bad;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (mix_out != 6'd0) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tone: no audible output before reset");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mix_out, signal_out, active} !== 10'd0) begin
            errors++;
            $display("FAIL midreset_async: mix=%0d sig=%0b act=%b, required all 0", mix_out, signal_out, active);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if ({mix_out, signal_out, active} !== 10'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d non-zero cycles, required 0", bad);
        end
        $display("test_reset_mid: tone=%0b quiet_bad=%0d", found, bad);
    endtask

    task automatic run_noise(output logic found, output int off);
        logic obs [64];
        int bad;
        logic ok;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_reg(2'd0, 2'd3, 8'h01);
        write_reg(2'd2, 2'd0, 8'd1);
        write_reg(2'd2, 2'd2, 8'h6F);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            obs[i] = (mix_out == 6'd15);
            if (mix_out != 6'd0 && mix_out != 6'd15) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL noise_levels: %0d samples not 0/15, required 0", bad);
        end
        found = 1'b0;
        off   = -1;
        for (int k = 0; k + 64 <= SEQ_LEN && !found; k++) begin
            ok = 1'b1;
            for (int j = 0; j < 64; j++) begin
                if (obs[j] != seq[k + j]) ok = 1'b0;
            end
            if (ok) begin
                found = 1'b1;
                off   = k;
            end
        end
    endtask

    task automatic test_noise_restart();
        logic f1, f2;
        int o1, o2;
        run_noise(f1, o1);
        checks++;
        if (f1 !== 1'b1) begin
            errors++;
            $display("FAIL noise_run1_match: not found in LFSR sequence, required a match");
        end
        run_noise(f2, o2);
        checks++;
        if (f2 !== 1'b1) begin
            errors++;
            $display("FAIL noise_run2_match: not found in LFSR sequence, required a match");
        end
        checks++;
        if (o2 !== o1) begin
            errors++;
            $display("FAIL noise_restart_offset: run2 offset %0d, required %0d", o2, o1);
        end
        $display("test_noise_restart: run1 offset=%0d run2 offset=%0d", o1, o2);
    endtask

    initial begin
        logic [14:0] s;
        s = 15'h0001;
        for (int i = 0; i < SEQ_LEN; i++) begin
            seq[i] = s[0];
            s = {s[13:0], s[14] ^ s[13]};
        end
        test_reset();
        test_square();
        test_pulse();
        test_chord();
        test_master();
        test_ignored();
        test_reset_mid();
        test_noise_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
